// File: rtl/nucleotide_word_reader_pkg.sv
// Shared constants and types for the nucleotide word reader: symbol packing,
// nucleotide encoding and FSM state encoding.
package nucleotide_word_reader_pkg;

  localparam int NW_SYM_W         = 2;
  localparam int NW_SYMS_PER_WORD = 4;
  localparam int NW_ADDR_W        = 8;
  localparam int NW_LEN_W         = 10;

  typedef enum logic [1:0] {
    NT_A = 2'd0,
    NT_C = 2'd1,
    NT_G = 2'd2,
    NT_T = 2'd3
  } nucleotide_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SERVE = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // A one-symbol word still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nucleotide_word_reader_if.sv
// RAM read port and symbol stream of the nucleotide word reader.
// master = the reader, slave = RAM model plus downstream consumer.
interface nucleotide_word_reader_if #(
  parameter int ADDR_W        = 8,
  parameter int SYM_W         = 2,
  parameter int SYMS_PER_WORD = 4
);
  logic                           ram_rd_en;
  logic [ADDR_W-1:0]              ram_addr;
  logic [SYM_W*SYMS_PER_WORD-1:0] ram_rdata;
  logic                           sym_valid;
  logic                           sym_ready;
  logic [SYM_W-1:0]               sym;
  logic                           sym_last;

  modport master (
    output ram_rd_en, ram_addr, sym_valid, sym, sym_last,
    input  ram_rdata, sym_ready
  );

  modport slave (
    input  ram_rd_en, ram_addr, sym_valid, sym, sym_last,
    output ram_rdata, sym_ready
  );
endinterface

// File: rtl/nucleotide_word_reader_sym_word_counter.sv
// Per-word symbol counter, modulo SYMS_PER_WORD; wrap pulses on the transfer
// that consumes the last symbol of the current word.
module sym_word_counter
  import nucleotide_word_reader_pkg::*;
#(
  parameter int SYMS_PER_WORD = NW_SYMS_PER_WORD,
  parameter int CNT_W         = cnt_width(SYMS_PER_WORD)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic wrap
);

  logic [CNT_W-1:0] cnt;

  assign wrap = inc && (cnt == CNT_W'(SYMS_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || wrap) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nucleotide_word_reader.sv
// Fetches packed nucleotide words from the sequence RAM and streams them out
// one symbol at a time (symbol 0 in the LSBs) over a valid/ready handshake.
module nucleotide_word_reader
  import nucleotide_word_reader_pkg::*;
#(
  parameter int ADDR_W        = NW_ADDR_W,
  parameter int SYM_W         = NW_SYM_W,
  parameter int SYMS_PER_WORD = NW_SYMS_PER_WORD,
  parameter int LEN_W         = NW_LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    seq_len,
  nucleotide_word_reader_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int WORD_W = SYM_W * SYMS_PER_WORD;

  state_e              state;
  logic [WORD_W-1:0]   shift_reg;
  logic [LEN_W-1:0]    remaining;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                ram_rd_en_q;
  logic                sym_valid_q;
  logic                xfer;
  logic                wrap;

  assign xfer = (state == ST_SERVE) && sym_valid_q && bus.sym_ready;

  sym_word_counter #(
    .SYMS_PER_WORD (SYMS_PER_WORD)
  ) u_sym_word_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_LOAD),
    .inc  (xfer),
    .wrap (wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ram_rd_en_q <= 1'b0;
      ram_addr_q  <= '0;
      sym_valid_q <= 1'b0;
      done        <= 1'b0;
      shift_reg   <= '0;
      remaining   <= '0;
    end else begin
      ram_rd_en_q <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= seq_len;
            if (seq_len != '0) begin
              ram_rd_en_q <= 1'b1;
              ram_addr_q  <= base_addr;
              state       <= ST_FETCH;
            end else begin
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        // Read strobe is already on the bus; data arrives during LOAD.
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          shift_reg   <= bus.ram_rdata;
          sym_valid_q <= 1'b1;
          state       <= ST_SERVE;
        end
        ST_SERVE: begin
          if (xfer) begin
            shift_reg <= shift_reg >> SYM_W;
            remaining <= remaining - LEN_W'(1);
            // Finishing takes priority so a partial last word never triggers a refill.
            if (remaining == LEN_W'(1)) begin
              sym_valid_q <= 1'b0;
              done        <= 1'b1;
              state       <= ST_FIN;
            end else if (wrap) begin
              sym_valid_q <= 1'b0;
              ram_rd_en_q <= 1'b1;
              ram_addr_q  <= ram_addr_q + ADDR_W'(1);
              state       <= ST_FETCH;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_rd_en = ram_rd_en_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym       = shift_reg[SYM_W-1:0];
  assign bus.sym_last  = sym_valid_q && (remaining == LEN_W'(1));
  assign busy          = (state != ST_IDLE);

endmodule
